// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its watchdog.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } arb_owner_t;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Bus-cycle watchdog: flags a timeout in the BUSY cycle that reaches the limit.
// Latency: combinational flag from a registered count; no backpressure.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy_i,
    output logic timeout_o
);
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count is zero in the first BUSY cycle, so the limit-th BUSY cycle is the last.
    always_comb begin
        cnt_d = '0;
        if (busy_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = busy_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fetch/data arbiter onto one Wishbone-style bus; MEM_ARB_TIMEOUT_EN adds a watchdog and bus_err.
// Latency: request to ack is 2 cycles with zero-wait memory; one transaction per 3 cycles max.
// Backpressure: requests are held until ack; the bus stalls BUSY until bus_ack (or timeout).
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_sel,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                bus_cyc,
    output logic                bus_stb,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_adr,
    output logic [DATA_W-1:0]   bus_dat_o,
    output logic [DATA_W/8-1:0] bus_sel,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic                bus_err,
`endif
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_dat_i
);
    arb_state_t          state_q, state_d;
    arb_owner_t          owner_q, owner_d;
    logic                cyc_q, cyc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [DATA_W/8-1:0] sel_q, sel_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                timeout;
    logic [DATA_W-1:0]   resp_dat;

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q, err_d;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .busy_i    (state_q == BUSY),
        .timeout_o (timeout)
    );

    // A real ack in the limit cycle wins; only a true timeout is sticky.
    assign err_d   = err_q | (timeout & ~bus_ack);
    assign bus_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign resp_dat = bus_ack ? bus_dat_i : DATA_W'(TIMEOUT_RDATA);

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (d_read || d_write) begin
                    adr_d   = d_addr;
                    dat_d   = d_wdata;
                    sel_d   = d_sel;
                    we_d    = d_write;
                    owner_d = DATA;
                    cyc_d   = 1'b1;
                    state_d = BUSY;
                end else if (i_req) begin
                    adr_d   = i_addr;
                    dat_d   = '0;
                    sel_d   = '1;
                    we_d    = 1'b0;
                    owner_d = INST;
                    cyc_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus_ack || timeout) begin
                    cyc_d   = 1'b0;
                    state_d = DONE;
                    if (owner_q == DATA) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = resp_dat;
                    end else if (owner_q == INST) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = resp_dat;
                    end
                end
            end
            DONE: begin
                owner_d = NONE;
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                owner_d = NONE;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= NONE;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    assign bus_cyc   = cyc_q;
    assign bus_stb   = cyc_q;
    assign bus_we    = we_q;
    assign bus_adr   = adr_q;
    assign bus_dat_o = dat_q;
    assign bus_sel   = sel_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int LIMIT = 60;
    localparam int TO    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_sel = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        bus_cyc, bus_stb, bus_we;
    logic [31:0] bus_adr, bus_dat_o;
    logic [3:0]  bus_sel;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_dat_i = '0;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        bus_err;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_txn_t;

    bus_txn_t    txn_log[$];
    int          mem_wait  = 0;
    bit          mem_stall = 1'b0;
    logic [31:0] mem_data  = '0;
    int          wcnt = 0;
    int          i_ack_cnt = 0, d_ack_cnt = 0, overlap_cnt = 0, adr_unstable = 0;
    int          cyc_len = 0, last_cyc_len = 0;
    logic [31:0] busy_adr = '0;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_sel(d_sel), .d_ack(d_ack), .d_rdata(d_rdata),
        .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_we(bus_we), .bus_adr(bus_adr),
        .bus_dat_o(bus_dat_o), .bus_sel(bus_sel),
`ifdef MEM_ARB_TIMEOUT_EN
        .bus_err(bus_err),
`endif
        .bus_ack(bus_ack), .bus_dat_i(bus_dat_i)
    );

    always #5 clk = ~clk;

    // Memory responder: acks after mem_wait stalled BUSY cycles and logs what it saw.
    always @(negedge clk) begin
        if (bus_cyc && rst && !mem_stall && !bus_ack) begin
            if (wcnt >= mem_wait) begin
                bus_txn_t t;
                t.adr = bus_adr; t.we = bus_we; t.dat = bus_dat_o; t.sel = bus_sel;
                txn_log.push_back(t);
                bus_ack   = 1'b1;
                bus_dat_i = mem_data;
                wcnt      = 0;
            end else begin
                wcnt++;
            end
        end else begin
            bus_ack = 1'b0;
            if (!bus_cyc) wcnt = 0;
        end
    end

    always @(negedge clk) begin
        if (i_ack) i_ack_cnt++;
        if (d_ack) d_ack_cnt++;
        if (i_ack && d_ack) overlap_cnt++;
        if (bus_cyc) begin
            if (cyc_len == 0) busy_adr = bus_adr;
            else if (bus_adr !== busy_adr) adr_unstable++;
            if (bus_stb !== 1'b1) adr_unstable++;
            cyc_len++;
        end else begin
            if (cyc_len != 0) last_cyc_len = cyc_len;
            cyc_len = 0;
        end
    end

    // Stimulus helper only: waits for an ack and withdraws the acked request in the DONE cycle.
    task automatic wait_ack(output int cycles, output bit got_i, output bit got_d);
        cycles = -1; got_i = 1'b0; got_d = 1'b0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (i_ack || d_ack) begin
                cycles = c; got_i = i_ack; got_d = d_ack;
                if (i_ack) i_req = 1'b0;
                if (d_ack) begin d_read = 1'b0; d_write = 1'b0; end
                break;
            end
        end
    endtask

    task automatic test_reset;
        int cyc; bit gi, gd;
        rst = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0040; mem_wait = 0; mem_data = 32'h1111_2222;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_cyc !== 1'b0) $display("FAIL reset_cyc got %0h want 0", bus_cyc); else n_pass++;
        n_checks++; if (bus_stb !== 1'b0 || bus_we !== 1'b0) $display("FAIL reset_stb_we got %0h%0h want 00", bus_stb, bus_we); else n_pass++;
        n_checks++; if (bus_adr !== 32'h0 || bus_dat_o !== 32'h0 || bus_sel !== 4'h0) $display("FAIL reset_bus got %h %h %h want 0", bus_adr, bus_dat_o, bus_sel); else n_pass++;
        n_checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) $display("FAIL reset_ack got %0h%0h want 00", i_ack, d_ack); else n_pass++;
        n_checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL reset_rdata got %h %h want 0", i_rdata, d_rdata); else n_pass++;
`ifdef MEM_ARB_TIMEOUT_EN
        n_checks++; if (bus_err !== 1'b0) $display("FAIL reset_err got %0h want 0", bus_err); else n_pass++;
`endif
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_cyc !== 1'b1) $display("FAIL release_cyc got %0h want 1", bus_cyc); else n_pass++;
        n_checks++; if (bus_adr !== 32'h40 || bus_sel !== 4'hF) $display("FAIL release_adr got %h/%h want 00000040/f", bus_adr, bus_sel); else n_pass++;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gi && !gd && cyc == 1)) $display("FAIL release_ack got i=%0d d=%0d cyc=%0d want i=1 d=0 cyc=1", gi, gd, cyc); else n_pass++;
    endtask

    task automatic test_fetch;
        int cyc; bit gi, gd;
        @(negedge clk);
        txn_log.delete();
        mem_wait = 0; mem_data = 32'h0000_0093; i_addr = 32'h0000_0010; i_req = 1'b1;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gi && !gd && cyc == 2)) $display("FAIL fetch_latency got i=%0d d=%0d cyc=%0d want i=1 d=0 cyc=2", gi, gd, cyc); else n_pass++;
        n_checks++; if (i_rdata !== 32'h93) $display("FAIL fetch_rdata got %h want 00000093", i_rdata); else n_pass++;
        n_checks++; if (txn_log.size() != 1 || txn_log[0].adr !== 32'h10 || txn_log[0].we !== 1'b0 || txn_log[0].dat !== 32'h0)
            $display("FAIL fetch_bus got n=%0d want one read of 00000010", txn_log.size()); else n_pass++;
        @(negedge clk);
        n_checks++; if (i_ack !== 1'b0 || i_rdata !== 32'h93) $display("FAIL fetch_hold got ack=%0h rdata=%h want 0/00000093", i_ack, i_rdata); else n_pass++;
    endtask

    task automatic test_priority;
        int cyc; bit gi, gd;
        @(negedge clk);
        txn_log.delete();
        mem_wait = 0; mem_data = 32'h0000_1234;
        i_req = 1'b1; i_addr = 32'h0000_0020;
        d_write = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hCAFE_F00D; d_sel = 4'b0011;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gd && !gi && cyc == 2)) $display("FAIL prio_first got i=%0d d=%0d cyc=%0d want d first cyc=2", gi, gd, cyc); else n_pass++;
        n_checks++; if (txn_log.size() != 1 || txn_log[0].we !== 1'b1 || txn_log[0].sel !== 4'b0011 ||
                        txn_log[0].adr !== 32'h100 || txn_log[0].dat !== 32'hCAFE_F00D)
            $display("FAIL prio_store got n=%0d want store 100/cafef00d/3", txn_log.size()); else n_pass++;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gi && !gd && cyc == 3)) $display("FAIL prio_fetch got i=%0d d=%0d cyc=%0d want i=1 cyc=3", gi, gd, cyc); else n_pass++;
        n_checks++; if (txn_log.size() != 2 || txn_log[1].we !== 1'b0 || txn_log[1].adr !== 32'h20 || txn_log[1].sel !== 4'hF)
            $display("FAIL prio_fetch_bus got n=%0d want fetch of 00000020", txn_log.size()); else n_pass++;
    endtask

    task automatic test_wait_states;
        int cyc, base_d; bit gi, gd;
        @(negedge clk);
        base_d = d_ack_cnt; adr_unstable = 0;
        mem_wait = 3; mem_data = 32'hA5A5_0001;
        d_read = 1'b1; d_addr = 32'h0000_0200; d_sel = 4'hF;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gd && !gi && cyc == 5)) $display("FAIL wait_latency got i=%0d d=%0d cyc=%0d want d cyc=5", gi, gd, cyc); else n_pass++;
        n_checks++; if (d_rdata !== 32'hA5A5_0001) $display("FAIL wait_rdata got %h want a5a50001", d_rdata); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (last_cyc_len != 4) $display("FAIL wait_cyc_len got %0d want 4", last_cyc_len); else n_pass++;
        n_checks++; if (adr_unstable != 0) $display("FAIL wait_stable got %0d want 0", adr_unstable); else n_pass++;
        n_checks++; if (d_ack_cnt - base_d != 1) $display("FAIL wait_one_ack got %0d want 1", d_ack_cnt - base_d); else n_pass++;
        mem_wait = 0;
    endtask

    task automatic test_reset_mid;
        int cyc, base_i, base_d; bit gi, gd;
        @(negedge clk);
        txn_log.delete();
        base_i = i_ack_cnt; base_d = d_ack_cnt;
        mem_stall = 1'b1; mem_data = 32'h0BAD_F00D; i_addr = 32'h0000_0300; i_req = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (bus_cyc !== 1'b1) $display("FAIL midrst_busy got %0h want 1", bus_cyc); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0 || bus_adr !== 32'h0) $display("FAIL midrst_clear got cyc=%0h adr=%h want 0", bus_cyc, bus_adr); else n_pass++;
        @(negedge clk);
        rst = 1'b1; mem_stall = 1'b0;
        n_checks++; if (i_ack_cnt != base_i || d_ack_cnt != base_d) $display("FAIL midrst_noack got %0d want 0", i_ack_cnt - base_i + d_ack_cnt - base_d); else n_pass++;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gi && cyc == 2 && i_rdata === 32'h0BAD_F00D)) $display("FAIL midrst_restart got i=%0d cyc=%0d rdata=%h want 1/2/0badf00d", gi, cyc, i_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (i_ack_cnt - base_i != 1 || txn_log.size() != 1) $display("FAIL midrst_single got acks=%0d txns=%0d want 1/1", i_ack_cnt - base_i, txn_log.size()); else n_pass++;
    endtask

    task automatic test_random;
        int cyc; bit gi, gd;
        logic [2:0]  kind;
        bit          data_win, known_i, known_d;
        logic [31:0] m_i_rdata, m_d_rdata, e_adr, e_dat;
        logic [3:0]  e_sel;
        logic        e_we;
        known_i = 1'b0; known_d = 1'b0; m_i_rdata = '0; m_d_rdata = '0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            txn_log.delete();
            kind     = 3'($urandom_range(1, 7));
            i_addr   = $urandom; d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom);
            mem_wait = $urandom_range(0, 3); mem_data = $urandom;
            i_req = kind[0]; d_read = kind[1]; d_write = kind[2];
            data_win = kind[1] | kind[2];
            e_adr = data_win ? d_addr : i_addr;
            e_we  = kind[2];
            e_dat = data_win ? d_wdata : 32'h0;
            e_sel = data_win ? d_sel : 4'hF;
            wait_ack(cyc, gi, gd);
            i_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
            n_checks++; if (gd != data_win || gi != !data_win || cyc != mem_wait + 2)
                $display("FAIL rand%0d_ack got i=%0d d=%0d cyc=%0d want d=%0d cyc=%0d", t, gi, gd, cyc, data_win, mem_wait + 2); else n_pass++;
            n_checks++; if (txn_log.size() != 1 || txn_log[0].adr !== e_adr || txn_log[0].we !== e_we ||
                            txn_log[0].dat !== e_dat || txn_log[0].sel !== e_sel)
                $display("FAIL rand%0d_bus got n=%0d want %h/%0h/%h/%h", t, txn_log.size(), e_adr, e_we, e_dat, e_sel); else n_pass++;
            if (data_win) begin m_d_rdata = mem_data; known_d = 1'b1; end
            else begin m_i_rdata = mem_data; known_i = 1'b1; end
            n_checks++; if ((known_i && i_rdata !== m_i_rdata) || (known_d && d_rdata !== m_d_rdata))
                $display("FAIL rand%0d_rdata got %h/%h want %h/%h", t, i_rdata, d_rdata, m_i_rdata, m_d_rdata); else n_pass++;
        end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int cyc; bit gi, gd;
        @(negedge clk);
        mem_stall = 1'b1; d_read = 1'b1; d_addr = 32'h0000_0400;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gd && cyc == TO + 1)) $display("FAIL timeout_ack got d=%0d cyc=%0d want 1/%0d", gd, cyc, TO + 1); else n_pass++;
        n_checks++; if (d_rdata !== 32'hDEAD_BEEF) $display("FAIL timeout_rdata got %h want deadbeef", d_rdata); else n_pass++;
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b1) $display("FAIL timeout_err got %0h want 1", bus_err); else n_pass++;
        mem_stall = 1'b0; mem_data = 32'h5555_AAAA; i_addr = 32'h44; i_req = 1'b1;
        wait_ack(cyc, gi, gd);
        n_checks++; if (!(gi && bus_err === 1'b1 && i_rdata === 32'h5555_AAAA)) $display("FAIL timeout_sticky got i=%0d err=%0h want 1/1", gi, bus_err); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus_err !== 1'b0) $display("FAIL timeout_clear got %0h want 0", bus_err); else n_pass++;
        rst = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_wait_states();
        test_reset_mid();
        test_random();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++; if (overlap_cnt != 0) $display("FAIL ack_overlap got %0d want 0", overlap_cnt); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got still running want finished");
        $fatal(1, "bench time limit");
    end

endmodule
